// File: rtl/count_chk_pkg.sv
// Shared types, default widths and the saturating-increment helper for
// the counter sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_ERR_CNT_W   = 8;
  localparam int DEF_WRAP_CNT_W  = 8;
  localparam int DEF_RESYNC_MISS = 3;

  // Wide enough for the largest legal RESYNC_MISS (15).
  localparam int MISS_W = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value == max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over inc.
module sat_counter
  import count_chk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), 32'(ALL_ONES)));
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that count_in advances by exactly +1 (mod 2^WIDTH) each clock,
// counting mismatches and wraps, and re-acquiring after RESYNC_MISS misses.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ERR_CNT_W   = DEF_ERR_CNT_W,
  parameter int WRAP_CNT_W  = DEF_WRAP_CNT_W,
  parameter int RESYNC_MISS = DEF_RESYNC_MISS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      count_in,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]      expected
);

  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  state_t            state_q, state_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic              pulse_q, pulse_d;
  logic              sticky_q, sticky_d;
  logic              err_inc, wrap_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      miss_q   <= '0;
      exp_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      exp_q    <= exp_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  // NOTE: every signal gets a default before any branch so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    exp_d    = exp_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    err_inc  = 1'b0;
    wrap_inc = 1'b0;

    if (!en) begin
      state_d = IDLE;
      miss_d  = '0;
    end else begin
      case (state_q)
        IDLE, HUNT: begin
          exp_d   = count_in + CNT_ONE;
          state_d = TRACK;
        end
        TRACK: begin
          exp_d = exp_q + CNT_ONE;
          if (count_in == exp_q) begin
            miss_d   = '0;
            wrap_inc = (count_in == '0);
          end else begin
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            err_inc  = 1'b1;
            if (int'(miss_q) + 1 < RESYNC_MISS) begin
              miss_d = miss_q + MISS_ONE;
            end else begin
              miss_d  = '0;
              state_d = HUNT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear beats a same-edge set; the pulse still reports the mismatch.
    if (clr) sticky_d = 1'b0;
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .clr  (clr),
    .q    (err_cnt)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wrap_inc),
    .clr  (clr),
    .q    (wrap_cnt)
  );

  assign locked     = (state_q == TRACK);
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign expected   = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_count_seq_checker;

  localparam int WIDTH  = 4;
  localparam int ERR_W  = 8;
  localparam int WRAP_W = 8;
  localparam int RESYNC = 3;
  localparam int MOD    = 1 << WIDTH;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic [WIDTH-1:0]  count_in;
  logic              locked;
  logic              err_pulse;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  expected;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_seq_checker #(
    .WIDTH      (WIDTH),
    .ERR_CNT_W  (ERR_W),
    .WRAP_CNT_W (WRAP_W),
    .RESYNC_MISS(RESYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .count_in  (count_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt),
    .expected  (expected)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: mode 0 = not checking, 1 = re-acquiring, 2 = checking.
  int m_mode, m_miss, m_exp, m_err, m_wrap;
  bit m_pulse, m_sticky;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_miss <= 0; m_exp <= 0; m_err <= 0; m_wrap <= 0;
      m_pulse <= 1'b0; m_sticky <= 1'b0;
    end else begin : model_step
      automatic int mode = m_mode;
      automatic int miss = m_miss;
      automatic int ex   = m_exp;
      automatic int err  = m_err;
      automatic int wrap = m_wrap;
      automatic int c    = int'(count_in);
      automatic bit pulse  = 1'b0;
      automatic bit sticky = m_sticky;
      if (!en) begin
        mode = 0;
        miss = 0;
      end else if (mode != 2) begin
        ex   = (c + 1) % MOD;
        mode = 2;
      end else if (c == ex) begin
        ex   = (ex + 1) % MOD;
        miss = 0;
        if (c == 0 && wrap < WRAP_MAX) wrap = wrap + 1;
      end else begin
        pulse  = 1'b1;
        sticky = 1'b1;
        if (err < ERR_MAX) err = err + 1;
        ex   = (ex + 1) % MOD;
        miss = miss + 1;
        if (miss == RESYNC) begin
          miss = 0;
          mode = 1;
        end
      end
      if (clr) begin
        err = 0; wrap = 0; sticky = 1'b0;
      end
      m_mode <= mode; m_miss <= miss; m_exp <= ex; m_err <= err; m_wrap <= wrap;
      m_pulse <= pulse; m_sticky <= sticky;
    end
  end

  always @(negedge clk) begin
    check("locked",     32'(locked),     32'(m_mode == 2));
    check("err_pulse",  32'(err_pulse),  32'(m_pulse));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("err_cnt",    32'(err_cnt),    32'(m_err));
    check("wrap_cnt",   32'(wrap_cnt),   32'(m_wrap));
    check("expected",   32'(expected),   32'(m_exp));
  end

  // Drive one sample at the current falling edge; return at the next one.
  task automatic step(input logic e, input logic c, input int v);
    en       = e;
    clr      = c;
    count_in = WIDTH'(v);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},  32'(locked),     32'd0);
    check({tag, "_pulse"},   32'(err_pulse),  32'd0);
    check({tag, "_sticky"},  32'(err_sticky), 32'd0);
    check({tag, "_err"},     32'(err_cnt),    32'd0);
    check({tag, "_wrap"},    32'(wrap_cnt),   32'd0);
    check({tag, "_exp"},     32'(expected),   32'd0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; count_in = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sequence 0..15,0..3
    step(1, 0, 0);
    check("clean_first_lock", 32'(locked), 32'd1);
    for (int i = 1; i < 20; i++) step(1, 0, i % 16);
    check("clean_exp",    32'(expected),   32'd4);
    check("clean_wrap",   32'(wrap_cnt),   32'd1);
    check("clean_err",    32'(err_cnt),    32'd0);
    check("clean_sticky", 32'(err_sticky), 32'd0);

    // Skip: 4,5,7,8,9,10,11
    step(1, 0, 4); step(1, 0, 5);
    check("skip_no_err", 32'(err_pulse), 32'd0);
    step(1, 0, 7);
    check("skip_pulse7", 32'(err_pulse), 32'd1);
    step(1, 0, 8);
    check("skip_pulse8", 32'(err_pulse), 32'd1);
    step(1, 0, 9);
    check("skip_pulse9", 32'(err_pulse), 32'd1);
    check("skip_hunt",   32'(locked),    32'd0);
    step(1, 0, 10);
    check("skip_relock", 32'(locked),    32'd1);
    check("skip_hunt_noerr", 32'(err_pulse), 32'd0);
    step(1, 0, 11);
    check("skip_11_noerr", 32'(err_pulse), 32'd0);
    check("skip_err_cnt",  32'(err_cnt),   32'd3);

    // Stuck at 3 for 400 cycles: 100 groups of 3 errors + 1 hunt
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      step(1, 0, 3);
      if (err_pulse === 1'b1) pulses++;
    end
    check("stuck_pulses", 32'(pulses),     32'd300);
    check("stuck_sat",    32'(err_cnt),    32'd255);
    check("stuck_sticky", 32'(err_sticky), 32'd1);

    // Build err_cnt = 5, then clr on a mismatching edge
    step(1, 1, 4);
    check("clr_match_err", 32'(err_cnt), 32'd0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    check("clr_pre_err", 32'(err_cnt), 32'd5);
    step(1, 1, 0);
    check("clr_pulse",  32'(err_pulse),  32'd1);
    check("clr_err",    32'(err_cnt),    32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);

    // Build err_cnt = 2, wrap_cnt = 1, then drop enable
    step(1, 0, 14); step(1, 0, 15); step(1, 0, 0);
    step(1, 0, 5);  step(1, 0, 2);  step(1, 0, 9);
    check("drop_pre_err",  32'(err_cnt),  32'd2);
    check("drop_pre_wrap", 32'(wrap_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 7);
      check("drop_locked", 32'(locked),   32'd0);
      check("drop_err",    32'(err_cnt),  32'd2);
      check("drop_wrap",   32'(wrap_cnt), 32'd1);
      check("drop_exp",    32'(expected), 32'd4);
    end
    step(1, 0, 9);
    check("relock_exp",    32'(expected),  32'd10);
    check("relock_locked", 32'(locked),    32'd1);
    check("relock_noerr",  32'(err_pulse), 32'd0);

    // Async reset between edges during TRACK
    step(1, 0, 10);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("areset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1, 0, 3); step(1, 0, 4); step(1, 0, 5);
    check("post_reset_exp",    32'(expected), 32'd6);
    check("post_reset_locked", 32'(locked),   32'd1);
    check("post_reset_err",    32'(err_cnt),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
